// File: rtl/r200_pipe_ctrl.sv
// ============================================================================
// Module: r200_pipe_ctrl
//
// Purpose
//   Parametrised pipeline controller for the r200 core. It tracks destination
//   information for in-flight instructions in NSTAGES post-decode stages
//   (stage 1 = EX ... stage NSTAGES = WB). From that state it produces:
//     - per-source forwarding selects for the instruction in ID
//     - the load-use interlock
//     - the global freeze on a busy data memory
//     - flushes for redirects resolved in ID and in EX
//     - PC and IF/ID enables and the ID/EX bubble for the datapath
//
// Parameters
//   NSTAGES     post-ID stages tracked
//   REGADDR_W   register address width
//   NUM_SRC     source operands per instruction
//   LOAD_STAGE  first stage whose output carries load data (1 < LOAD_STAGE <= NSTAGES)
//   SEL_W       width of one forwarding select (derived)
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_rst_n            asynchronous reset, active low
//   i_id_valid         ID holds a real instruction
//   i_id_rs            source addresses, src i = [i*REGADDR_W +: REGADDR_W]
//   i_id_rs_used       source i is actually read
//   i_id_rd            destination address of the ID instruction
//   i_id_regwr         ID instruction writes rd
//   i_id_isload        ID instruction is a load
//   i_id_redirect      jump resolved in ID
//   i_ex_redirect      branch taken or jump resolved in EX
//   i_mem_stall        data memory busy, freeze the whole pipe
//   o_pc_en            PC may update
//   o_if_id_en         IF/ID register may load
//   o_if_id_flush      IF/ID loads a NOP
//   o_id_ex_flush      ID/EX loads a bubble
//   o_load_use_stall   interlock active this cycle
//   o_fwd_sel          per source: 0 = regfile, k = forward from stage k output
//   o_stage_valid      registered valid bit per stage, bit k-1 = stage k
// ============================================================================
module r200_pipe_ctrl #(
    parameter int NSTAGES    = 3,
    parameter int REGADDR_W  = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(NSTAGES + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_id_valid,
    input  logic [NUM_SRC*REGADDR_W-1:0]   i_id_rs,
    input  logic [NUM_SRC-1:0]             i_id_rs_used,
    input  logic [REGADDR_W-1:0]           i_id_rd,
    input  logic                           i_id_regwr,
    input  logic                           i_id_isload,
    input  logic                           i_id_redirect,
    input  logic                           i_ex_redirect,
    input  logic                           i_mem_stall,
    output logic                           o_pc_en,
    output logic                           o_if_id_en,
    output logic                           o_if_id_flush,
    output logic                           o_id_ex_flush,
    output logic                           o_load_use_stall,
    output logic [NUM_SRC*SEL_W-1:0]       o_fwd_sel,
    output logic [NSTAGES-1:0]             o_stage_valid
);

    // Per-cycle pipeline action, in priority order. ACT_RESET only appears
    // while i_rst_n is low and drives the safe reset values on the outputs.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_EX_REDIR,
        ACT_LOAD_USE,
        ACT_ID_REDIR,
        ACT_NORMAL
    } action_t;

    // Stage state; index k-1 holds stage k.
    logic [NSTAGES-1:0]   r_valid;
    logic [NSTAGES-1:0]   r_regwr;
    logic [NSTAGES-1:0]   r_isload;
    logic [REGADDR_W-1:0] r_rd [NSTAGES];

    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic                     w_hazard;
    logic [REGADDR_W-1:0]     w_src_rs;
    logic [SEL_W-1:0]         w_src_sel;
    logic                     w_src_early_load;
    action_t                  w_action;
    logic                     w_id_enters;
    logic                     w_advance;

    // Forwarding and load-use detection. The stage scan runs from the oldest
    // stage down to stage 1 so the last hit, i.e. the nearest producer,
    // overrides any older one. Only the nearest producer decides the
    // interlock: if it is a load whose data is not yet available at that
    // stage's output, ID has to wait even if an older stage also matches.
    always_comb begin
        w_fwd_sel        = '0;
        w_hazard         = 1'b0;
        w_src_rs         = '0;
        w_src_sel        = '0;
        w_src_early_load = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src_rs         = i_id_rs[i*REGADDR_W +: REGADDR_W];
            w_src_sel        = '0;
            w_src_early_load = 1'b0;
            if (i_id_valid && i_id_rs_used[i] && (w_src_rs != '0)) begin
                for (int k = NSTAGES; k >= 1; k--) begin
                    if (r_valid[k-1] && r_regwr[k-1] && (r_rd[k-1] == w_src_rs)) begin
                        w_src_sel        = SEL_W'(k);
                        w_src_early_load = r_isload[k-1] && (k < LOAD_STAGE);
                    end
                end
            end
            w_fwd_sel[i*SEL_W +: SEL_W] = w_src_sel;
            if (w_src_early_load) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Pick the single action for this cycle. A busy memory freezes
    // everything, a redirect from EX kills the load-use wait because the
    // dependent instruction in ID is on the wrong path anyway, and an ID
    // jump is dropped during an interlock since ID re-issues next cycle.
    always_comb begin
        w_action = ACT_NORMAL;
        if (!i_rst_n) begin
            w_action = ACT_RESET;
        end else if (i_mem_stall) begin
            w_action = ACT_FREEZE;
        end else if (i_ex_redirect) begin
            w_action = ACT_EX_REDIR;
        end else if (w_hazard) begin
            w_action = ACT_LOAD_USE;
        end else if (i_id_redirect) begin
            w_action = ACT_ID_REDIR;
        end
    end

    // Control outputs decoded from the chosen action. Forwarding selects are
    // passed through except in reset, where the datapath must read the
    // register file.
    always_comb begin
        o_pc_en          = 1'b1;
        o_if_id_en       = 1'b1;
        o_if_id_flush    = 1'b0;
        o_id_ex_flush    = 1'b0;
        o_load_use_stall = 1'b0;
        o_fwd_sel        = w_fwd_sel;
        w_id_enters      = 1'b0;
        w_advance        = 1'b1;
        unique case (w_action)
            ACT_RESET: begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
                o_fwd_sel     = '0;
                w_advance     = 1'b0;
            end
            ACT_FREEZE: begin
                o_pc_en    = 1'b0;
                o_if_id_en = 1'b0;
                w_advance  = 1'b0;
            end
            ACT_EX_REDIR: begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end
            ACT_LOAD_USE: begin
                o_pc_en          = 1'b0;
                o_if_id_en       = 1'b0;
                o_id_ex_flush    = 1'b1;
                o_load_use_stall = 1'b1;
            end
            ACT_ID_REDIR: begin
                o_if_id_flush = 1'b1;
                w_id_enters   = 1'b1;
            end
            ACT_NORMAL: begin
                w_id_enters = 1'b1;
            end
            default: begin
                w_advance = 1'b0;
            end
        endcase
    end

    // Stage registers. On every non-frozen edge the older stages shift by
    // one and stage 1 takes either the ID instruction or a bubble. A write
    // to x0 is recorded as no write so it can never be forwarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= '0;
            r_regwr  <= '0;
            r_isload <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else if (w_advance) begin
            for (int k = NSTAGES - 1; k >= 1; k--) begin
                r_valid[k]  <= r_valid[k-1];
                r_regwr[k]  <= r_regwr[k-1];
                r_isload[k] <= r_isload[k-1];
                r_rd[k]     <= r_rd[k-1];
            end
            if (w_id_enters) begin
                r_valid[0]  <= i_id_valid;
                r_rd[0]     <= i_id_rd;
                r_regwr[0]  <= i_id_regwr && (i_id_rd != '0);
                r_isload[0] <= i_id_isload;
            end else begin
                r_valid[0]  <= 1'b0;
                r_rd[0]     <= '0;
                r_regwr[0]  <= 1'b0;
                r_isload[0] <= 1'b0;
            end
        end
    end

    assign o_stage_valid = r_valid;

endmodule

// File: tb/tb_r200_pipe_ctrl.sv
// ============================================================================
// Testbench: tb_r200_pipe_ctrl
//
// Purpose
//   Directed, self-checking bench for r200_pipe_ctrl with default parameters
//   (3 stages, 5-bit register addresses, 2 sources, loads ready at stage 2).
//   Each scenario task drives the ID-side inputs, steps the clock and
//   compares the controller outputs against hand-computed values.
// ============================================================================
module tb_r200_pipe_ctrl;

    localparam int NSTAGES   = 3;
    localparam int REGADDR_W = 5;
    localparam int NUM_SRC   = 2;
    localparam int SEL_W     = 2;

    logic                         clk;
    logic                         rst_n;
    logic                         id_valid;
    logic [NUM_SRC*REGADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]           id_rs_used;
    logic [REGADDR_W-1:0]         id_rd;
    logic                         id_regwr;
    logic                         id_isload;
    logic                         id_redirect;
    logic                         ex_redirect;
    logic                         mem_stall;
    logic                         pc_en;
    logic                         if_id_en;
    logic                         if_id_flush;
    logic                         id_ex_flush;
    logic                         load_use_stall;
    logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
    logic [NSTAGES-1:0]           stage_valid;

    int errors = 0;
    int checks = 0;

    r200_pipe_ctrl #(
        .NSTAGES    (NSTAGES),
        .REGADDR_W  (REGADDR_W),
        .NUM_SRC    (NUM_SRC),
        .LOAD_STAGE (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_id_valid       (id_valid),
        .i_id_rs          (id_rs),
        .i_id_rs_used     (id_rs_used),
        .i_id_rd          (id_rd),
        .i_id_regwr       (id_regwr),
        .i_id_isload      (id_isload),
        .i_id_redirect    (id_redirect),
        .i_ex_redirect    (ex_redirect),
        .i_mem_stall      (mem_stall),
        .o_pc_en          (pc_en),
        .o_if_id_en       (if_id_en),
        .o_if_id_flush    (if_id_flush),
        .o_id_ex_flush    (id_ex_flush),
        .o_load_use_stall (load_use_stall),
        .o_fwd_sel        (fwd_sel),
        .o_stage_valid    (stage_valid)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    // Present one instruction in ID.
    task automatic setId(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic wr, input logic ld);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        id_rd      = rd;
        id_regwr   = wr;
        id_isload  = ld;
    endtask

    task automatic setCtl(input logic idr, input logic exr, input logic ms);
        id_redirect = idr;
        ex_redirect = exr;
        mem_stall   = ms;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        setId(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        bubble();
        setCtl(1'b0, 1'b0, 1'b0);
        repeat (NSTAGES) tick();
        checks++;
        if (stage_valid !== 3'b000) begin
            errors++;
            $display("[TB] FAIL drain_empty: got %b expected 000", stage_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setCtl(1'b0, 1'b0, 1'b0);
        setId(1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, 1'b0);
        #2;
        checks++;
        if ({stage_valid, pc_en, if_id_en, if_id_flush, id_ex_flush, load_use_stall, fwd_sel} !== {3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got sv=%b pc=%b ifid=%b iff=%b idf=%b lus=%b fwd=%b expected sv=000 pc=0 ifid=0 iff=1 idf=1 lus=0 fwd=0000",
                     stage_valid, pc_en, if_id_en, if_id_flush, id_ex_flush, load_use_stall, fwd_sel);
        end
        tick();
        checks++;
        if (stage_valid !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b expected 000", stage_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bubble();
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected 1100", {pc_en, if_id_en, if_id_flush, id_ex_flush});
        end
    endtask

    task automatic test_dependent_alu();
        setId(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
        tick();
        checks++;
        if (stage_valid !== 3'b001) begin
            errors++;
            $display("[TB] FAIL alu_latency: got %b expected 001", stage_valid);
        end
        setId(1'b1, 5'd5, 5'd3, 2'b11, 5'd8, 1'b1, 1'b0);
        #1;
        checks++;
        if ({fwd_sel, load_use_stall, pc_en, id_ex_flush} !== {4'b0001, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL alu_fwd: got fwd=%b lus=%b pc=%b idf=%b expected fwd=0001 lus=0 pc=1 idf=0",
                     fwd_sel, load_use_stall, pc_en, id_ex_flush);
        end
        tick();
        // x5 now in stage 2, x8 in stage 1; read both.
        setId(1'b1, 5'd8, 5'd5, 2'b11, 5'd9, 1'b1, 1'b0);
        #1;
        checks++;
        if (fwd_sel !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL alu_fwd_two: got %b expected 1001", fwd_sel);
        end
        drain();
    endtask

    task automatic test_load_use();
        setId(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0);
        tick();
        bubble();
        tick();
        setId(1'b1, 5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);
        tick();
        checks++;
        if (stage_valid !== 3'b101) begin
            errors++;
            $display("[TB] FAIL lu_setup: got %b expected 101", stage_valid);
        end
        setId(1'b1, 5'd6, 5'd6, 2'b11, 5'd7, 1'b1, 1'b0);
        #1;
        checks++;
        if ({load_use_stall, pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_sel} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101}) begin
            errors++;
            $display("[TB] FAIL lu_stall: got lus=%b pc=%b ifid=%b iff=%b idf=%b fwd=%b expected lus=1 pc=0 ifid=0 iff=0 idf=1 fwd=0101",
                     load_use_stall, pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_sel);
        end
        tick();
        checks++;
        if ({stage_valid, load_use_stall, pc_en, id_ex_flush, fwd_sel} !== {3'b010, 1'b0, 1'b1, 1'b0, 4'b1010}) begin
            errors++;
            $display("[TB] FAIL lu_release: got sv=%b lus=%b pc=%b idf=%b fwd=%b expected sv=010 lus=0 pc=1 idf=0 fwd=1010",
                     stage_valid, load_use_stall, pc_en, id_ex_flush, fwd_sel);
        end
        tick();
        checks++;
        if (stage_valid !== 3'b101) begin
            errors++;
            $display("[TB] FAIL lu_reissue: got %b expected 101", stage_valid);
        end
        drain();
    endtask

    task automatic test_nearest_wins();
        // Oldest: x5, then an x0 "writer", then x5 again.
        setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd0, 5'd5, 2'b11, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if (fwd_sel !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL nearest_src1: got %b expected 0100", fwd_sel);
        end
        setId(1'b1, 5'd0, 5'd5, 2'b01, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL unused_src: got %b expected 0000", fwd_sel);
        end
        setId(1'b0, 5'd5, 5'd5, 2'b11, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL invalid_id: got %b expected 0000", fwd_sel);
        end
        tick();
        // Stage 2 now holds x5 and stage 3 the x0 writer.
        setId(1'b1, 5'd5, 5'd0, 2'b11, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if (fwd_sel !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL stage2_fwd: got %b expected 0010", fwd_sel);
        end
        drain();
    endtask

    task automatic test_redirects();
        setId(1'b1, 5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);
        tick();
        setId(1'b1, 5'd6, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0);
        setCtl(1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({load_use_stall, pc_en, if_id_en, if_id_flush, id_ex_flush} !== 5'b01111) begin
            errors++;
            $display("[TB] FAIL exr_over_lu: got %b expected 01111",
                     {load_use_stall, pc_en, if_id_en, if_id_flush, id_ex_flush});
        end
        tick();
        checks++;
        if (stage_valid !== 3'b010) begin
            errors++;
            $display("[TB] FAIL exr_bubble: got %b expected 010", stage_valid);
        end
        drain();
        // id_redirect is ignored under a load-use interlock.
        setId(1'b1, 5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);
        setCtl(1'b0, 1'b0, 1'b0);
        tick();
        setId(1'b1, 5'd6, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0);
        setCtl(1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if ({load_use_stall, pc_en, if_id_flush, id_ex_flush} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL lu_over_idr: got %b expected 1001",
                     {load_use_stall, pc_en, if_id_flush, id_ex_flush});
        end
        tick();
        // Interlock over; the jump now takes effect and ID enters stage 1.
        #1;
        checks++;
        if ({load_use_stall, pc_en, if_id_en, if_id_flush, id_ex_flush} !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL id_redirect: got %b expected 01110",
                     {load_use_stall, pc_en, if_id_en, if_id_flush, id_ex_flush});
        end
        tick();
        checks++;
        if (stage_valid !== 3'b101) begin
            errors++;
            $display("[TB] FAIL idr_enters: got %b expected 101", stage_valid);
        end
        drain();
    endtask

    task automatic test_mem_stall();
        setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0);
        tick();
        setId(1'b1, 5'd11, 5'd10, 2'b11, 5'd12, 1'b1, 1'b0);
        setCtl(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({stage_valid, fwd_sel, pc_en, if_id_en, if_id_flush, id_ex_flush} !== {3'b011, 4'b1001, 4'b0000}) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: got sv=%b fwd=%b ctl=%b expected sv=011 fwd=1001 ctl=0000",
                         c, stage_valid, fwd_sel, {pc_en, if_id_en, if_id_flush, id_ex_flush});
            end
            tick();
        end
        setCtl(1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({stage_valid, fwd_sel, pc_en} !== {3'b011, 4'b1001, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stall_release: got sv=%b fwd=%b pc=%b expected sv=011 fwd=1001 pc=1",
                     stage_valid, fwd_sel, pc_en);
        end
        tick();
        checks++;
        if (stage_valid !== 3'b111) begin
            errors++;
            $display("[TB] FAIL stall_resume: got %b expected 111", stage_valid);
        end
    endtask

    task automatic test_async_reset();
        // Pipe is full here; freeze it, then reset between edges.
        setCtl(1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stage_valid, pc_en, if_id_flush, id_ex_flush} !== {3'b000, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL async_reset: got sv=%b pc=%b iff=%b idf=%b expected sv=000 pc=0 iff=1 idf=1",
                     stage_valid, pc_en, if_id_flush, id_ex_flush);
        end
        @(negedge clk);
        rst_n = 1'b1;
        setCtl(1'b0, 1'b0, 1'b0);
        setId(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b0);
        tick();
        checks++;
        if (stage_valid !== 3'b001) begin
            errors++;
            $display("[TB] FAIL post_reset_issue: got %b expected 001", stage_valid);
        end
    endtask

    initial begin
        test_reset();
        test_dependent_alu();
        test_load_use();
        test_nearest_wins();
        test_redirects();
        test_mem_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
